// File: rtl/ahbtoaxi_handshake_tx.sv
// ---------------------------------------------------------------------------
// ahbtoaxi_handshake_tx
//   Source side of a four-phase req/ack handshake that carries a payload into
//   an asynchronous destination domain. The payload is latched on acceptance
//   and held stable on data_out while req_out is high. ack_in is brought into
//   the CLK domain through a SYNC_STAGES-deep flop chain. A saturating wait
//   counter raises a sticky err flag when a handshake stalls, but the FSM
//   never aborts the handshake.
//
// Ports
//   CLK       in   source-domain clock, rising edge
//   rst       in   asynchronous active-high reset
//   send      in   one-cycle transfer request
//   din       in   payload, sampled when send is accepted
//   ack_in    in   acknowledge level from the destination (asynchronous)
//   req_out   out  request level to the destination
//   data_out  out  held payload
//   busy      out  handshake in progress
//   done      out  one-cycle completion pulse
//   ovr       out  one-cycle pulse when a send is dropped
//   err       out  sticky timeout flag
//
// state  | meaning
// IDLE   | no handshake, send accepted here
// REQ_HI | req_out high, waiting for synchronized ack to rise
// REQ_LO | req_out low, waiting for synchronized ack to fall
// ---------------------------------------------------------------------------
module ahbtoaxi_handshake_tx #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ack_in,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovr,
  output logic                  err
);

  // A zero timeout still needs a legal (1-bit) counter; it is simply held at 0.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_sync;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   req_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   done_q;
  logic                   ovr_q;
  logic                   err_q;

  // ack synchronizer: stage 0 is the only flop that sees the raw async input.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_sync = sync_q[SYNC_STAGES-1];

  // Saturating increment of the wait counter.
  always_comb begin
    cnt_d = cnt_q;
    if (TIMEOUT_EN && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      // A send outside IDLE is dropped and flagged; nothing else changes.
      ovr_q  <= send && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (send) begin
            state_q <= REQ_HI;
            data_q  <= din;
            req_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        REQ_HI: begin
          if (ack_sync) begin
            state_q <= REQ_LO;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
            if (TIMEOUT_EN && (cnt_d == CNT_MAX)) err_q <= 1'b1;
          end
        end
        REQ_LO: begin
          if (!ack_sync) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
            if (TIMEOUT_EN && (cnt_d == CNT_MAX)) err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_out  = req_q;
  assign data_out = data_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ovr      = ovr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ahbtoaxi_handshake_tx.sv
// ---------------------------------------------------------------------------
// tb_ahbtoaxi_handshake_tx
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model (phase number, ack delay line, wait count) predicts every
//   output each cycle.
// ---------------------------------------------------------------------------
module tb_ahbtoaxi_handshake_tx;

  localparam int S  = 2;
  localparam int T  = 8;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          send;
  logic [DW-1:0] din;
  logic          ack_in;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          ovr;
  logic          err;

  ahbtoaxi_handshake_tx #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK     (clk),
    .rst     (rst),
    .send    (send),
    .din     (din),
    .ack_in  (ack_in),
    .req_out (req_out),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .ovr     (ovr),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = request raised, 2 = request lowered.
  // The FSM sees ack_in as it was sampled S edges earlier.
  int          m_phase;
  int          m_wait;
  logic [DW-1:0] m_data;
  bit          m_done;
  bit          m_ovr;
  bit          m_err;
  bit          ack_hist[$];

  task automatic model_reset();
    m_phase = 0;
    m_wait  = 0;
    m_data  = '0;
    m_done  = 0;
    m_ovr   = 0;
    m_err   = 0;
    ack_hist.delete();
  endtask

  task automatic bump_wait();
    if (m_wait < T) m_wait++;
    if (m_wait == T) m_err = 1;
  endtask

  task automatic model_edge();
    bit seen;
    seen = (ack_hist.size() >= S) ? ack_hist[ack_hist.size() - S] : 1'b0;
    ack_hist.push_back(ack_in);
    if (ack_hist.size() > 8) void'(ack_hist.pop_front());
    m_done = 0;
    m_ovr  = (m_phase != 0) && send;
    case (m_phase)
      0: if (send) begin m_phase = 1; m_data = din; m_wait = 0; end
      1: if (seen) begin m_phase = 2; m_wait = 0; end else bump_wait();
      2: if (!seen) begin m_phase = 0; m_done = 1; end else bump_wait();
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    check_eq("req_out",  req_out,  m_phase == 1);
    check_eq("data_out", data_out, m_data);
    check_eq("busy",     busy,     m_phase != 0);
    check_eq("done",     done,     m_done);
    check_eq("ovr",      ovr,      m_ovr);
    check_eq("err",      err,      m_err);
  endtask

  // One clock: model advances on the edge, outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic finish_xfer();
    int n;
    ack_in = 1'b1;
    n = 0;
    while (m_phase != 2 && n < 12) begin tick(); n++; end
    check_eq("xfer_ack_rise_bound", n >= 12, 0);
    ack_in = 1'b0;
    n = 0;
    while (!m_done && n < 12) begin tick(); n++; end
    check_eq("xfer_ack_fall_bound", n >= 12, 0);
  endtask

  int n;
  int dones;
  int stall;

  initial begin
    rst    = 1'b1;
    send   = 1'b0;
    din    = '0;
    ack_in = 1'b0;
    model_reset();
    #1;
    check_eq("rst_req_out",  req_out,  0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_busy",     busy,     0);
    check_eq("rst_err",      err,      0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic transfer with an overrun while REQ_HI.
    send = 1'b1; din = 32'hDEADBEEF;
    tick();
    send = 1'b0;
    check_eq("basic_req",  req_out,  1);
    check_eq("basic_data", data_out, 32'hDEADBEEF);
    check_eq("basic_busy", busy,     1);
    send = 1'b1; din = 32'h12345678;
    tick();
    send = 1'b0;
    check_eq("ovr_pulse", ovr,      1);
    check_eq("ovr_data",  data_out, 32'hDEADBEEF);
    tick();
    check_eq("ovr_single", ovr, 0);
    ack_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (req_out && n < 10);
    check_eq("ack_to_req_low_edges", n, S + 1);
    ack_in = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!done && n < 10);
    check_eq("ack_to_done_edges", n, S + 1);
    check_eq("done_busy", busy, 0);

    // Back-to-back: send in the done cycle.
    send = 1'b1; din = 32'h00000001;
    tick();
    send = 1'b0;
    check_eq("b2b_req",  req_out,  1);
    check_eq("b2b_data", data_out, 32'h00000001);
    check_eq("b2b_ovr",  ovr,      0);
    finish_xfer();

    // Timeout with ack held low.
    send = 1'b1; din = 32'hA5A50F0F;
    tick();
    send = 1'b0;
    repeat (T - 1) tick();
    check_eq("tmo_before", err, 0);
    tick();
    check_eq("tmo_set", err, 1);
    check_eq("tmo_still_req", req_out, 1);
    finish_xfer();
    check_eq("tmo_sticky", err, 1);
    check_eq("tmo_done", done, 1);

    // Reset while REQ_LO.
    send = 1'b1; din = 32'h0BADF00D;
    tick();
    send = 1'b0;
    ack_in = 1'b1;
    n = 0;
    while (m_phase != 2 && n < 12) begin tick(); n++; end
    check_eq("rst_mid_reach_lo", m_phase, 2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_mid_req",  req_out, 0);
    check_eq("rst_mid_busy", busy,    0);
    check_eq("rst_mid_err",  err,     0);
    ack_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    send = 1'b1; din = 32'hCAFE0001;
    tick();
    send = 1'b0;
    check_eq("post_rst_req",  req_out,  1);
    check_eq("post_rst_data", data_out, 32'hCAFE0001);
    finish_xfer();

    // Ack glitches while REQ_HI.
    send = 1'b1; din = 32'h5555AAAA;
    tick();
    send = 1'b0;
    #2 ack_in = 1'b1;
    #2 ack_in = 1'b0;
    repeat (4) tick();
    check_eq("glitch_missed_req", req_out, 1);
    #6 ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    dones = 0;
    repeat (10) begin tick(); dones += int'(done); end
    check_eq("glitch_single_done", dones, 1);
    check_eq("glitch_idle", busy, 0);

    // Randomized traffic.
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 1'b0;
      send = ($urandom_range(3) == 0);
      din  = $urandom;
      if (stall > 0) stall--;
      else if ($urandom_range(39) == 0) stall = $urandom_range(15);
      else if ((ack_in != (m_phase == 1)) && $urandom_range(1) == 1) ack_in = ~ack_in;
      if ($urandom_range(299) == 0) begin
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
